// File: rtl/sap_cpu_core.sv
// SAP-style accumulator CPU: PC/MAR/IR/A, carry/zero flags, internal RAM and a
// microstep FSM, with a host program-load port and a run/halt handshake.
module sap_cpu_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_prog_we,
    input  logic [ADDR_WIDTH-1:0] i_prog_addr,
    input  logic [DATA_WIDTH-1:0] i_prog_data,
    input  logic                  i_run,
    output logic                  o_busy,
    output logic                  o_halted,
    output logic [DATA_WIDTH-1:0] o_out_val,
    output logic                  o_out_valid,
    output logic                  o_flag_carry,
    output logic                  o_flag_zero
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h3;
    localparam logic [3:0] OpSta = 4'h4;
    localparam logic [3:0] OpLdi = 4'h5;
    localparam logic [3:0] OpJmp = 4'h6;
    localparam logic [3:0] OpJc  = 4'h7;
    localparam logic [3:0] OpJz  = 4'h8;
    localparam logic [3:0] OpOut = 4'hE;
    localparam logic [3:0] OpHlt = 4'hF;

    typedef enum logic [2:0] {StIdle, StFetch0, StFetch1, StExec0, StExec1, StHalt} state_e;

    state_e                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
    logic [ADDR_WIDTH-1:0] r_mar, w_mar_next;
    logic [DATA_WIDTH-1:0] r_ir, w_ir_next;
    logic [DATA_WIDTH-1:0] r_a, w_a_next;
    logic                  r_c, w_c_next;
    logic                  r_z, w_z_next;
    logic [DATA_WIDTH-1:0] r_out_val, w_out_val_next;
    logic                  r_out_valid, w_out_valid_next;
    logic [DATA_WIDTH-1:0] r_ram [Depth];

    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_waddr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;

    logic [DATA_WIDTH-1:0] w_mem;
    logic [3:0]            w_opcode;
    logic [ADDR_WIDTH-1:0] w_operand;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_diff;

    assign w_mem     = r_ram[r_mar];
    assign w_opcode  = r_ir[DATA_WIDTH-1 -: 4];
    assign w_operand = r_ir[ADDR_WIDTH-1:0];
    assign w_sum     = {1'b0, r_a} + {1'b0, w_mem};
    assign w_diff    = r_a - w_mem;

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_mar_next       = r_mar;
        w_ir_next        = r_ir;
        w_a_next         = r_a;
        w_c_next         = r_c;
        w_z_next         = r_z;
        w_out_val_next   = r_out_val;
        w_out_valid_next = 1'b0;
        w_ram_we         = 1'b0;
        w_ram_waddr      = i_prog_addr;
        w_ram_wdata      = i_prog_data;
        case (r_state)
            StIdle, StHalt: begin
                w_ram_we = i_prog_we;
                if (i_run) begin
                    w_pc_next    = '0;
                    w_a_next     = '0;
                    w_c_next     = 1'b0;
                    w_z_next     = 1'b0;
                    w_state_next = StFetch0;
                end
            end
            StFetch0: begin
                w_mar_next   = r_pc;
                w_state_next = StFetch1;
            end
            StFetch1: begin
                w_ir_next    = w_mem;
                w_pc_next    = r_pc + ADDR_WIDTH'(1);
                w_state_next = StExec0;
            end
            StExec0: begin
                w_state_next = StFetch0;
                case (w_opcode)
                    OpLda, OpAdd, OpSub, OpSta: begin
                        w_mar_next   = w_operand;
                        w_state_next = StExec1;
                    end
                    OpLdi: w_a_next = DATA_WIDTH'(w_operand);
                    OpJmp: w_pc_next = w_operand;
                    OpJc:  if (r_c) w_pc_next = w_operand;
                    OpJz:  if (r_z) w_pc_next = w_operand;
                    OpOut: begin
                        w_out_val_next   = r_a;
                        w_out_valid_next = 1'b1;
                    end
                    OpHlt: w_state_next = StHalt;
                    default: ;
                endcase
            end
            StExec1: begin
                w_state_next = StFetch0;
                case (w_opcode)
                    OpLda: w_a_next = w_mem;
                    OpAdd: begin
                        {w_c_next, w_a_next} = w_sum;
                        w_z_next = (w_sum[DATA_WIDTH-1:0] == '0);
                    end
                    OpSub: begin
                        w_a_next = w_diff;
                        w_c_next = (r_a >= w_mem);
                        w_z_next = (w_diff == '0);
                    end
                    OpSta: begin
                        w_ram_we    = 1'b1;
                        w_ram_waddr = r_mar;
                        w_ram_wdata = r_a;
                    end
                    default: ;
                endcase
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_pc        <= '0;
            r_mar       <= '0;
            r_ir        <= '0;
            r_a         <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_out_val   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_mar       <= w_mar_next;
            r_ir        <= w_ir_next;
            r_a         <= w_a_next;
            r_c         <= w_c_next;
            r_z         <= w_z_next;
            r_out_val   <= w_out_val_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    // RAM is never cleared; reset only blocks a write in flight (e.g. an aborted STA).
    always_ff @(posedge clk) begin
        if (!reset && w_ram_we) begin
            r_ram[w_ram_waddr] <= w_ram_wdata;
        end
    end

    assign o_busy       = (r_state == StFetch0) || (r_state == StFetch1) ||
                          (r_state == StExec0)  || (r_state == StExec1);
    assign o_halted     = (r_state == StHalt);
    assign o_out_val    = r_out_val;
    assign o_out_valid  = r_out_valid;
    assign o_flag_carry = r_c;
    assign o_flag_zero  = r_z;

endmodule

// File: tb/tb_sap_cpu_core.sv
// Self-checking bench for sap_cpu_core: directed programs plus random programs
// checked against an instruction-level interpreter.
module tb_sap_cpu_core;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_prog_we = 1'b0;
    logic [3:0] i_prog_addr = '0;
    logic [7:0] i_prog_data = '0;
    logic       i_run = 1'b0;
    logic       o_busy, o_halted, o_out_valid, o_flag_carry, o_flag_zero;
    logic [7:0] o_out_val;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] prog [16];
    logic [7:0] d_outs [$];
    bit         d_c [$];
    bit         d_z [$];
    int         d_n [$];
    int         halt_n;

    int         m_mem [16];
    int         m_outs [$];
    int         m_c, m_z, m_cycles;
    bit         m_halted;

    sap_cpu_core #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_prog_we    (i_prog_we),
        .i_prog_addr  (i_prog_addr),
        .i_prog_data  (i_prog_data),
        .i_run        (i_run),
        .o_busy       (o_busy),
        .o_halted     (o_halted),
        .o_out_val    (o_out_val),
        .o_out_valid  (o_out_valid),
        .o_flag_carry (o_flag_carry),
        .o_flag_zero  (o_flag_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else n_pass++;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            i_prog_we   = 1'b1;
            i_prog_addr = 4'(i);
            i_prog_data = prog[i];
        end
        @(negedge clk);
        i_prog_we = 1'b0;
    endtask

    // n counts rising edges after the run edge; sampling happens on falling edges.
    task automatic run_prog(input int max_n, input bit poke);
        d_outs.delete(); d_c.delete(); d_z.delete(); d_n.delete();
        halt_n = -1;
        @(negedge clk);
        i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        for (int n = 0; n <= max_n; n++) begin
            if (n > 0) @(negedge clk);
            i_prog_we   = poke && (n >= 1) && (n <= 10);
            i_prog_addr = 4'd14;
            i_prog_data = 8'd99;
            if (o_out_valid) begin
                d_outs.push_back(o_out_val);
                d_c.push_back(o_flag_carry);
                d_z.push_back(o_flag_zero);
                d_n.push_back(n);
            end
            if (o_halted) begin
                halt_n = n;
                break;
            end
        end
        i_prog_we = 1'b0;
        n_checks++;
        if (halt_n < 0) $display("FAIL run_timeout: got no halt within %0d cycles", max_n);
        else n_pass++;
    endtask

    // Instruction-level interpreter: one loop iteration per instruction.
    task automatic model_run(input int max_instr);
        int pc, a, w, op, opd, s;
        pc = 0; a = 0; m_c = 0; m_z = 0; m_cycles = 0; m_halted = 0;
        m_outs.delete();
        for (int k = 0; k < max_instr && !m_halted; k++) begin
            w = m_mem[pc];
            pc = (pc + 1) % 16;
            op = w / 16;
            opd = w % 16;
            m_cycles += (op >= 1 && op <= 4) ? 4 : 3;
            case (op)
                1: a = m_mem[opd];
                2: begin s = a + m_mem[opd]; m_c = int'(s > 255); a = s % 256; m_z = int'(a == 0); end
                3: begin m_c = int'(a >= m_mem[opd]); a = (a - m_mem[opd] + 256) % 256; m_z = int'(a == 0); end
                4: m_mem[opd] = a;
                5: a = opd;
                6: pc = opd;
                7: if (m_c != 0) pc = opd;
                8: if (m_z != 0) pc = opd;
                14: m_outs.push_back(a);
                15: m_halted = 1;
                default: ;
            endcase
        end
    endtask

    task automatic test2_prog();
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'hE0; prog[3] = 8'hF0;
        prog[14] = 8'd28; prog[15] = 8'd14;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", int'(o_busy), 0);
        check("reset_halted", int'(o_halted), 0);
        check("reset_out_val", int'(o_out_val), 0);
        check("reset_out_valid", int'(o_out_valid), 0);
        check("reset_carry", int'(o_flag_carry), 0);
        check("reset_zero", int'(o_flag_zero), 0);
    endtask

    task automatic test_add_out();
        test2_prog();
        load_prog();
        run_prog(40, 1'b0);
        check("add_out_pulses", d_outs.size(), 1);
        if (d_outs.size() == 1) begin
            check("add_out_val", int'(d_outs[0]), 42);
            check("add_out_cycle", d_n[0] + 1, 12);
        end
        check("add_halt_cycle", halt_n, 14);
        check("add_carry", int'(o_flag_carry), 0);
        check("add_zero", int'(o_flag_zero), 0);
        check("add_busy_in_halt", int'(o_busy), 0);
    endtask

    task automatic test_jc();
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h79; prog[3] = 8'hF0;
        prog[9] = 8'hE0; prog[10] = 8'hF0; prog[14] = 8'd200; prog[15] = 8'd100;
        load_prog();
        run_prog(60, 1'b0);
        check("jc_out_pulses", d_outs.size(), 1);
        check("jc_out_val", int'(o_out_val), 44);
        check("jc_carry", int'(o_flag_carry), 1);
        check("jc_zero", int'(o_flag_zero), 0);
        check("jc_halted", int'(o_halted), 1);
    endtask

    task automatic test_sub_jz();
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h3E; prog[2] = 8'h85; prog[3] = 8'hF0;
        prog[5] = 8'hE0; prog[6] = 8'h55; prog[7] = 8'h3F; prog[8] = 8'hE0;
        prog[9] = 8'hF0; prog[14] = 8'd77; prog[15] = 8'd6;
        load_prog();
        run_prog(80, 1'b0);
        check("subjz_out_pulses", d_outs.size(), 2);
        if (d_outs.size() == 2) begin
            check("sub_eq_val", int'(d_outs[0]), 0);
            check("sub_eq_zero", int'(d_z[0]), 1);
            check("sub_eq_carry", int'(d_c[0]), 1);
            check("sub_borrow_val", int'(d_outs[1]), 255);
            check("sub_borrow_carry", int'(d_c[1]), 0);
            check("sub_borrow_zero", int'(d_z[1]), 0);
        end
    endtask

    task automatic test_sta_wrap();
        clear_prog();
        prog[0] = 8'h1D; prog[1] = 8'hE0; prog[2] = 8'h57; prog[3] = 8'h4D;
        prog[4] = 8'h1C; prog[5] = 8'h40; prog[6] = 8'h1D; prog[7] = 8'hE0;
        prog[8] = 8'h6F; prog[12] = 8'hF0; prog[13] = 8'h33; prog[15] = 8'h00;
        load_prog();
        run_prog(120, 1'b0);
        check("sta_out_pulses", d_outs.size(), 2);
        if (d_outs.size() == 2) begin
            check("sta_old_val", int'(d_outs[0]), 8'h33);
            check("sta_lda_back", int'(d_outs[1]), 7);
        end
        check("pc_wrap_halt_cycle", halt_n, 38);
    endtask

    task automatic test_busy_and_reset();
        test2_prog();
        load_prog();
        run_prog(40, 1'b1);
        check("busy_we_out_val", int'(o_out_val), 42);
        clear_prog();
        prog[0] = 8'h53; prog[1] = 8'h4E; prog[2] = 8'hF0; prog[14] = 8'd28;
        load_prog();
        @(negedge clk);
        i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", int'(o_busy), 0);
        check("abort_halted", int'(o_halted), 0);
        // Reload everything except word 14, which the aborted STA must not have touched.
        test2_prog();
        for (int i = 0; i < 16; i++) begin
            if (i == 14) continue;
            @(negedge clk);
            i_prog_we   = 1'b1;
            i_prog_addr = 4'(i);
            i_prog_data = prog[i];
        end
        @(negedge clk);
        i_prog_we = 1'b0;
        run_prog(40, 1'b0);
        check("rerun_out_val", int'(o_out_val), 42);
        check("rerun_halt_cycle", halt_n, 14);
    endtask

    task automatic test_random();
        int done;
        done = 0;
        for (int tries = 0; tries < 200 && done < 10; tries++) begin
            for (int i = 0; i < 16; i++) begin
                prog[i] = 8'($urandom_range(0, 255));
                m_mem[i] = int'(prog[i]);
            end
            model_run(60);
            if (!m_halted) continue;
            done++;
            load_prog();
            run_prog(m_cycles + 10, 1'b0);
            check("rand_halt_cycle", halt_n, m_cycles);
            check("rand_out_count", d_outs.size(), m_outs.size());
            for (int i = 0; i < d_outs.size() && i < m_outs.size(); i++)
                check("rand_out_val", int'(d_outs[i]), m_outs[i]);
            check("rand_carry", int'(o_flag_carry), m_c);
            check("rand_zero", int'(o_flag_zero), m_z);
        end
        n_checks++;
        if (done < 10) $display("FAIL rand_programs: got %0d halting programs expected 10", done);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add_out();
        test_jc();
        test_sub_jz();
        test_sta_wrap();
        test_busy_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
